// File: rtl/cr_isf_ib_arb.sv
// cr_isf_ib_arb: frame-level round-robin arbiter merging up to four AXI4-stream
// TLV sources onto the ISF ingress bus through one output pipeline register.
// It also provides per-source enables, an output-stall watchdog and per-frame
// completion strobes.

package axi4s_dp_pkg;
  typedef struct packed {
    logic        tvalid;
    logic        tlast;
    logic [7:0]  tid;
    logic [7:0]  tuser;
    logic [7:0]  tstrb;
    logic [63:0] tdata;
  } axi4s_dp_bus_t;

  typedef struct packed {
    logic tready;
  } axi4s_dp_rdy_t;
endpackage

module cr_isf_ib_arb
  import axi4s_dp_pkg::*;
#(
  parameter int N_SRC   = 2,
  parameter int STALL_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  axi4s_dp_bus_t       src_in [N_SRC],
  output axi4s_dp_rdy_t       src_out [N_SRC],
  output axi4s_dp_bus_t       ob_out,
  input  axi4s_dp_rdy_t       ob_in,
  input  logic [N_SRC-1:0]    cfg_src_en,
  input  logic [STALL_W-1:0]  cfg_stall_limit,
  output logic                arb_busy,
  output logic [1:0]          arb_grant,
  output logic                frame_done_stb,
  output logic [1:0]          frame_done_src,
  output logic                stall_stb
);

  localparam logic [1:0] LAST_IDX = 2'(N_SRC - 1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [1:0]          rr_ptr_q, rr_ptr_d;
  logic [1:0]          grant_q, grant_d;
  axi4s_dp_bus_t       ob_q, ob_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;

  axi4s_dp_bus_t       beat;
  logic [3:0]          cand;
  logic [2:0]          srch;
  logic                found;
  logic [1:0]          pick;
  logic                grant_rdy;
  logic                acc;
  logic                out_acc;
  logic                stalling;

  // Index after idx, wrapping from the last populated source back to 0.
  function automatic logic [1:0] nxt_idx(input logic [1:0] idx);
    return (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
  endfunction

  // Round-robin search from start; returns {found, index}.
  function automatic logic [2:0] rr_search(input logic [3:0] c, input logic [1:0] start);
    logic [2:0] r;
    logic [1:0] idx;
    r   = '0;
    idx = start;
    for (int k = 0; k < N_SRC; k++) begin
      if (!r[2] && c[idx]) r = {1'b1, idx};
      idx = nxt_idx(idx);
    end
    return r;
  endfunction

  // Candidate set for new grants and the beat offered by the granted source.
  always_comb begin
    cand = '0;
    beat = '0;
    for (int i = 0; i < N_SRC; i++) begin
      cand[i] = src_in[i].tvalid & cfg_src_en[i];
      if (grant_q == 2'(i)) beat = src_in[i];
    end
  end

  assign srch      = rr_search(cand, rr_ptr_q);
  assign found     = srch[2];
  assign pick      = srch[1:0];
  // The granted source may push whenever the output register is empty or draining.
  assign grant_rdy = !ob_q.tvalid || ob_in.tready;
  assign acc       = (state_q == LOCKED) && beat.tvalid && grant_rdy;
  assign out_acc   = ob_q.tvalid && ob_in.tready;
  assign stalling  = ob_q.tvalid && !ob_in.tready;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: lock on a found candidate, release on an accepted tlast beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = LOCKED;
      LOCKED:  if (acc && beat.tlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: busy flag, per-source readies and frame completion strobe.
  always_comb begin
    arb_busy       = (state_q == LOCKED);
    frame_done_stb = acc && beat.tlast;
    frame_done_src = grant_q;
    for (int i = 0; i < N_SRC; i++) begin
      src_out[i].tready = (state_q == LOCKED) && (grant_q == 2'(i)) && grant_rdy;
    end
  end

  // Grant capture in IDLE and pointer advance past the source that just finished.
  always_comb begin
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    if (state_q == IDLE && found) grant_d = pick;
    if (acc && beat.tlast)        rr_ptr_d = nxt_idx(grant_q);
  end

  // Output register next value: load accepted beats, drop tvalid when drained.
  always_comb begin
    ob_d = ob_q;
    if (acc) begin
      ob_d        = beat;
      ob_d.tvalid = 1'b1;
    end else if (ob_in.tready) begin
      ob_d.tvalid = 1'b0;
    end
  end

  // Stall counter: clears on output acceptance, counts stalled cycles, saturates.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_acc)                        stall_cnt_d = '0;
    else if (stalling && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + STALL_W'(1);
  end

  // Watchdog fires in the cycle the counter steps onto a non-zero limit.
  assign stall_stb = stalling && !(&stall_cnt_q) && (cfg_stall_limit != '0) &&
                     ((stall_cnt_q + STALL_W'(1)) == cfg_stall_limit);

  // Grant, round-robin pointer, output register and stall counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      ob_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      ob_q        <= ob_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ob_out    = ob_q;
  assign arb_grant = grant_q;

endmodule

// File: tb/tb_cr_isf_ib_arb.sv
// Directed bench for cr_isf_ib_arb with N_SRC = 2.
module tb_cr_isf_ib_arb;
  import axi4s_dp_pkg::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  axi4s_dp_bus_t  src_in [2];
  axi4s_dp_rdy_t  src_out [2];
  axi4s_dp_bus_t  ob_out;
  axi4s_dp_rdy_t  ob_in;
  logic [1:0]     cfg_src_en;
  logic [15:0]    cfg_stall_limit;
  logic           arb_busy;
  logic [1:0]     arb_grant;
  logic           frame_done_stb;
  logic [1:0]     frame_done_src;
  logic           stall_stb;

  int errs = 0;
  int nchk = 0;
  int bi [2];
  int len [2];
  int tot [2];
  logic hs [2];

  cr_isf_ib_arb #(.N_SRC(2), .STALL_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_in(src_in), .src_out(src_out),
    .ob_out(ob_out), .ob_in(ob_in),
    .cfg_src_en(cfg_src_en), .cfg_stall_limit(cfg_stall_limit),
    .arb_busy(arb_busy), .arb_grant(arb_grant),
    .frame_done_stb(frame_done_stb), .frame_done_src(frame_done_src),
    .stall_stb(stall_stb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic string tg(input string s, input int c);
    return $sformatf("%s@%0d", s, c);
  endfunction

  function automatic axi4s_dp_bus_t mk(input int s, input int b, input bit last);
    axi4s_dp_bus_t t;
    t.tvalid = 1'b1;
    t.tlast  = last;
    t.tid    = 8'(s);
    t.tuser  = 8'(8'h40 + b);
    t.tstrb  = 8'hFF;
    t.tdata  = {16'hA5A5, 16'(s), 32'(b)};
    return t;
  endfunction

  task automatic drive();
    for (int s = 0; s < 2; s++) begin
      if (bi[s] < tot[s]) src_in[s] = mk(s, bi[s], (bi[s] % len[s]) == len[s] - 1);
      else                src_in[s] = '0;
    end
  endtask

  // Close the current cycle: record handshakes, cross the edge, advance sources.
  task automatic step();
    for (int s = 0; s < 2; s++) hs[s] = src_in[s].tvalid && src_out[s].tready;
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) if (hs[s]) bi[s]++;
    drive();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin bi[s] = 0; tot[s] = 0; len[s] = 1; end
    drive();
    ob_in.tready    = 1'b1;
    cfg_src_en      = 2'b11;
    cfg_stall_limit = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load(input int s, input int l, input int t);
    bi[s] = 0; len[s] = l; tot[s] = t;
    drive();
  endtask

  initial begin
    do_reset();
    // Reset state
    #2;
    chk("rst_tvalid", ob_out.tvalid, 0);
    chk("rst_tdata", ob_out.tdata, 0);
    chk("rst_busy", arb_busy, 0);
    chk("rst_grant", arb_grant, 0);
    chk("rst_rdy0", src_out[0].tready, 0);
    chk("rst_rdy1", src_out[1].tready, 0);
    chk("rst_fds", frame_done_stb, 0);
    chk("rst_stall", stall_stb, 0);

    // Single source, 4-beat frame
    do_reset();
    load(0, 4, 4);
    for (int c = 0; c < 8; c++) begin
      #2;
      chk(tg("t1_busy", c), arb_busy, (c >= 1 && c <= 4));
      chk(tg("t1_vld", c), ob_out.tvalid, (c >= 2 && c <= 5));
      if (c >= 2 && c <= 5) begin
        chk(tg("t1_data", c), ob_out.tdata, mk(0, c - 2, 0).tdata);
        chk(tg("t1_last", c), ob_out.tlast, (c == 5));
      end
      chk(tg("t1_fds", c), frame_done_stb, (c == 4));
      if (c == 4) chk("t1_fdsrc", frame_done_src, 0);
      step();
    end

    // Contention: both sources, 3-beat frames
    do_reset();
    load(0, 3, 3);
    load(1, 3, 3);
    for (int c = 0; c < 10; c++) begin
      #2;
      chk(tg("t2_busy", c), arb_busy, ((c >= 1 && c <= 3) || (c >= 5 && c <= 7)));
      chk(tg("t2_rdy0", c), src_out[0].tready, (c >= 1 && c <= 3));
      chk(tg("t2_rdy1", c), src_out[1].tready, (c >= 5 && c <= 7));
      chk(tg("t2_vld", c), ob_out.tvalid, ((c >= 2 && c <= 4) || (c >= 6 && c <= 8)));
      if (c >= 2 && c <= 4) chk(tg("t2_data", c), ob_out.tdata, mk(0, c - 2, 0).tdata);
      if (c >= 6 && c <= 8) chk(tg("t2_data", c), ob_out.tdata, mk(1, c - 6, 0).tdata);
      chk(tg("t2_fds", c), frame_done_stb, (c == 3 || c == 7));
      if (c == 3) chk("t2_fdsrc0", frame_done_src, 0);
      if (c == 7) chk("t2_fdsrc1", frame_done_src, 1);
      if (c == 4) chk("t2_rrptr1", dut.rr_ptr_q, 1);
      if (c == 8) chk("t2_rrptr0", dut.rr_ptr_q, 0);
      step();
    end

    // Backpressure: ob_in.tready low for cycles 4..8, stall limit 3
    do_reset();
    cfg_stall_limit = 16'd3;
    load(0, 6, 6);
    for (int c = 0; c < 14; c++) begin
      int eb;
      ob_in.tready = !(c >= 4 && c <= 8);
      eb = (c < 4) ? c - 2 : (c <= 9) ? 2 : c - 7;
      #2;
      chk(tg("t3_vld", c), ob_out.tvalid, (c >= 2 && c <= 12));
      if (c >= 2 && c <= 12) begin
        chk(tg("t3_data", c), ob_out.tdata, mk(0, eb, 0).tdata);
        chk(tg("t3_last", c), ob_out.tlast, (c == 12));
      end
      chk(tg("t3_rdy0", c), src_out[0].tready, ((c >= 1 && c <= 3) || (c >= 9 && c <= 11)));
      chk(tg("t3_stall", c), stall_stb, (c == 6));
      chk(tg("t3_fds", c), frame_done_stb, (c == 11));
      step();
    end

    // Enable masking: only source 1 eligible, enable dropped mid-frame
    do_reset();
    cfg_src_en = 2'b10;
    load(0, 4, 4);
    load(1, 4, 8);
    for (int c = 0; c < 10; c++) begin
      if (c >= 2) cfg_src_en = 2'b00;
      #2;
      chk(tg("t4_busy", c), arb_busy, (c >= 1 && c <= 4));
      chk(tg("t4_grant", c), arb_grant, (c >= 1) ? 2'd1 : 2'd0);
      chk(tg("t4_rdy0", c), src_out[0].tready, 0);
      chk(tg("t4_rdy1", c), src_out[1].tready, (c >= 1 && c <= 4));
      chk(tg("t4_vld", c), ob_out.tvalid, (c >= 2 && c <= 5));
      chk(tg("t4_fds", c), frame_done_stb, (c == 4));
      if (c == 4) chk("t4_fdsrc", frame_done_src, 1);
      step();
    end

    // Reset mid-frame during beat 2 of 5 from source 1
    do_reset();
    load(1, 5, 5);
    for (int c = 0; c < 2; c++) step();
    #2;
    chk("t5_pre_grant", arb_grant, 1);
    chk("t5_pre_vld", ob_out.tvalid, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_vld", ob_out.tvalid, 0);
    chk("t5_rst_data", ob_out.tdata, 0);
    chk("t5_rst_busy", arb_busy, 0);
    chk("t5_rst_grant", arb_grant, 0);
    chk("t5_rst_rdy1", src_out[1].tready, 0);
    chk("t5_rst_fds", frame_done_stb, 0);
    do_reset();
    load(0, 2, 2);
    load(1, 2, 2);
    for (int c = 0; c < 3; c++) begin
      #2;
      chk(tg("t5_busy", c), arb_busy, (c >= 1));
      chk(tg("t5_grant", c), arb_grant, 0);
      chk(tg("t5_rdy0", c), src_out[0].tready, (c >= 1));
      chk(tg("t5_rdy1", c), src_out[1].tready, 0);
      if (c == 2) chk("t5_data", ob_out.tdata, mk(0, 0, 0).tdata);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

endmodule

// File: doc/cr_isf_ib_arb.md
# cr_isf_ib_arb

Frame-level round-robin arbiter that merges up to four AXI4-stream TLV sources onto the single ISF ingress bus (`isf_ib_in` of the ISF). A grant is locked from the first beat of a frame until its `tlast` beat is accepted, so frames are never interleaved. The output passes through one pipeline register. The block also provides per-source enables, a programmable output-stall watchdog and per-frame completion strobes for the stats path.

## Interface
- `N_SRC`, default 2: number of sources, legal range 2..4.
- `STALL_W`, default 16: width of the stall-limit counter.
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `src_in` in `axi4s_dp_bus_t` x `N_SRC`: source streams.
- `src_out` out `axi4s_dp_rdy_t` x `N_SRC`: per-source `tready`.
- `ob_out` out `axi4s_dp_bus_t`: merged stream into the ISF.
- `ob_in` in `axi4s_dp_rdy_t`: ISF `tready`.
- `cfg_src_en` in `N_SRC`: 1 = source eligible for new grants.
- `cfg_stall_limit` in `STALL_W`: stall watchdog threshold; 0 disables it.
- `arb_busy` out 1: high while in the LOCKED state.
- `arb_grant` out 2: index of the currently or last granted source.
- `frame_done_stb` out 1: one-cycle pulse when a `tlast` beat is accepted from a source.
- `frame_done_src` out 2: source index qualifying `frame_done_stb`.
- `stall_stb` out 1: one-cycle pulse when the watchdog fires.

## Operation
- State machine has two states, IDLE and LOCKED.
- **IDLE**
  - All `src_out.tready` are 0.
  - Candidate set = sources with `src_in[i].tvalid` high and `cfg_src_en[i]` high.
  - Search starts at `rr_ptr` and wraps modulo `N_SRC`. The first candidate found is registered into `arb_grant`, and the state moves to LOCKED on the next edge.
  - With no candidates, the state stays IDLE and `arb_grant` holds its value.
- **LOCKED**
  - `src_out[arb_grant].tready = !ob_out.tvalid || ob_in.tready`. All other readies are 0.
  - An accepted beat (source `tvalid` and `tready` both high) is loaded into the output register: `tdata`, `tstrb`, `tuser`, `tid` and `tlast` unmodified, `tvalid` = 1.
  - When the output register drains with no new beat loaded, `ob_out.tvalid` goes to 0.
  - When an accepted beat has `tlast` = 1:
    - `frame_done_stb` = 1 and `frame_done_src = arb_grant` in that same cycle (combinational from the accept).
    - Next state is IDLE.
    - `rr_ptr <= (arb_grant + 1) mod N_SRC`.
- **Source enable**
  - Deasserting `cfg_src_en` for the granted source mid-frame does not truncate the frame. The enable only gates new grants.
  - A source whose enable is 0 keeps `tready` = 0 while it is not granted.
- **Stall watchdog**
  - `stall_cnt` (`STALL_W` bits) increments every cycle that `ob_out.tvalid && !ob_in.tready`, and clears to 0 on any output acceptance.
  - It saturates at all-ones.
  - `stall_stb` pulses for exactly one cycle, in the cycle `stall_cnt` transitions to equal `cfg_stall_limit` (limit ≠ 0). It does not pulse again until the counter has been cleared.
  - The watchdog is observational only: the grant is not revoked.
- **Width rules**
  - `arb_grant`, `rr_ptr` and `frame_done_src` are 2 bits wide. Bits above `clog2(N_SRC)` are zero.
  - The wrap from index `N_SRC-1` goes to 0.

## Timing
- **Reset values:** state = IDLE, `rr_ptr` = 0, `arb_grant` = 0, `ob_out` all fields 0, all `src_out.tready` = 0, `arb_busy` = 0, `frame_done_stb` = 0, `frame_done_src` = 0, `stall_stb` = 0, `stall_cnt` = 0.
- **Reset mid-frame:** the output register and the grant are discarded immediately (asynchronous). No partial-frame recovery.
- **Grant latency:** a source asserts `tvalid` in cycle N while IDLE; the grant is registered at the end of N; `tready` is high in N+1; the first beat appears on `ob_out` in N+2.
- **Steady-state throughput:** one beat per cycle while `ob_in.tready` = 1.
- **Inter-frame bubble:** exactly one IDLE cycle between consecutive frames, including back-to-back frames from the same source.
- **Single-beat frame:** a first beat with `tlast` = 1 gives LOCKED for exactly one cycle.
- **Downstream backpressure:** while `ob_in.tready` = 0 with a beat held, `src_out.tready` = 0 and `ob_out` is stable. `tvalid` must not drop and the payload must not change.
- **Simultaneous requests:** all sources valid at once are served in strict rotation from `rr_ptr`. With `rr_ptr` = 1 and `N_SRC` = 3, the order is 1, 2, 0.

## Test plan
- **Single source:** `N_SRC` = 2, source 0 sends a 4-beat frame, `ob_in.tready` = 1. Expect the beats on `ob_out` in cycles 2..5 with payload unchanged, `tlast` on the 4th, `frame_done_stb` with src 0 in cycle 4, `arb_busy` high in cycles 1..4.
- **Contention:** both sources hold 3-beat frames from cycle 0. Expect source 0's frame, then one bubble, then source 1's frame with no interleaving, then `rr_ptr` = 0.
- **Backpressure:** `ob_in.tready` low for 5 cycles mid-frame with `cfg_stall_limit` = 3. Expect `ob_out` stable, granted `tready` = 0, `stall_stb` pulsing once on the 3rd stalled cycle, no data loss or duplication.
- **Enable masking:** `cfg_src_en` = 2'b10 with both sources valid. Expect only source 1 granted. Clearing bit 1 mid-frame still lets the frame complete; after that no grant is issued.
- **Reset mid-frame:** assert `rst_n` low during beat 2 of 5. Expect all outputs at their reset values immediately. After release, a fresh grant starts from source 0.
